cursor_stepper: RTL and testbench
=================================

// Module: cursor_stepper
// PURPOSE
//  Converts four held direction buttons into cursor X/Y coordinates for the
//  etch-a-sketch. Consumes the one-cycle strobe from the pulse generator as its
//  time base. Steps once on press, then auto-repeats after a hold delay.
//  Feeds the draw/framebuffer stage with coordinates and a one-cycle moved strobe.
// PARAMETERS
//  W             10   coordinate width (bits)
//  X_MAX         639  largest legal x; x range 0..X_MAX
//  Y_MAX         479  largest legal y; y range 0..Y_MAX
//  CW            8    repeat counter width
//  REPEAT_DELAY  16   ticks from the first step to the first repeat step (>=1)
//  REPEAT_PERIOD 4    ticks between repeat steps (>=1)
// PORTS
//  clk    in   1   clock
//  rst    in   1   synchronous reset, active-low; sampled on posedge clk
//  tick   in   1   one-cycle strobe from pulse_generator; the only time base
//  btn    in   4   raw buttons {up,down,left,right}; asynchronous; 1 = pressed
//  clear  in   1   synchronous recenter request
//  x      out  W   cursor x
//  y      out  W   cursor y (0 = top; up decrements)
//  moved  out  1   high for the one cycle in which x or y holds a new value
// BEHAVIOUR
//  - Reset (rst==0 at posedge): x=X_MAX/2, y=Y_MAX/2 (integer divide), moved=0,
//    state=IDLE, cnt=0, synchronizer flops=0. Reset has priority over all inputs.
//  - Synchronizer: btn passes through 2 flops to give btn_s. A press is
//    therefore visible 2 cycles after it is applied.
//  - Direction: dx = right-left, dy = down-up. Opposing pairs cancel to 0.
//    Diagonals are allowed.
//  - Step: the new coordinate is the old coordinate plus the delta, saturated
//    to 0..X_MAX or 0..Y_MAX. Registered: x/y change on the posedge that samples
//    the step tick. moved=1 in the following cycle only if x or y actually
//    changed. A step blocked by saturation gives moved=0.
//  - FSM states: IDLE, DELAY, REPEAT. cnt counts ticks only.
//    IDLE:   btn_s!=0 && tick -> step; go to DELAY; cnt=0.
//            btn_s!=0 without tick -> wait in IDLE.
//    DELAY:  on tick: if cnt==REPEAT_DELAY-1 -> step; go to REPEAT; cnt=0.
//            Otherwise cnt++.
//    REPEAT: on tick: if cnt==REPEAT_PERIOD-1 -> step; cnt=0. Otherwise cnt++.
//    Any state, btn_s==0 -> go to IDLE; cnt=0; no step. This rule takes
//    priority over tick in the same cycle.
//    Any state, btn_s changes to a different nonzero pattern -> go to IDLE;
//    cnt=0. The new pattern is handled as a new press.
//  - With REPEAT_DELAY=1 and REPEAT_PERIOD=1, the cursor steps on every tick
//    while a button is held.
//  - clear (rst==1): x/y return to the reset center, state=IDLE, cnt=0,
//    moved=0. clear beats a coincident step.
//  - cnt never wraps; it is bounded by the compare.
//  - Ticks with no button held are ignored. tick held high continuously is
//    legal and is treated as a tick every cycle.
// TESTING
//  - Reset: rst=0 for 2 cycles -> x=319, y=239, moved=0. Holding btn during
//    reset has no effect.
//  - Single press: right held, tick every 4 clk. First tick after btn_s
//    asserts -> x=320, moved=1 for 1 cycle. Release before 16 ticks -> no
//    further change.
//  - Auto-repeat: right held for 16+3*4 ticks after the first step -> x
//    sequence 320 (1st), 321 (tick 16), 322, 323, 324. Exactly 5 moved pulses.
//  - Saturation: clear, then left held with REPEAT_DELAY=REPEAT_PERIOD=1 for
//    400 ticks -> x stops at 0. moved pulses=319. No moved pulse once pinned.
//    Repeat the test for y at Y_MAX using down.
//  - Cancel/diagonal: left+right held -> x unchanged, no moved.
//    up+right held -> (320,238) on the first step.
//  - Priority: clear with a step tick in the same cycle -> center, moved=0.
//    Release the button on a tick cycle -> no step.
//    rst=0 mid-REPEAT -> center, IDLE; the next press waits for a new tick.

Source files
------------

// File: rtl/cursor_stepper.sv
// rtl/cursor_stepper.sv - held direction buttons to saturating cursor X/Y with hold-delay auto-repeat
module cursor_stepper #(
    parameter int W             = 10,
    parameter int X_MAX         = 639,
    parameter int Y_MAX         = 479,
    parameter int CW            = 8,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [3:0]   btn,
    input  logic         clear,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         moved
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    localparam logic [W-1:0]  X_CTR   = W'(X_MAX / 2);
    localparam logic [W-1:0]  Y_CTR   = W'(Y_MAX / 2);
    localparam logic [W-1:0]  X_LIM   = W'(X_MAX);
    localparam logic [W-1:0]  Y_LIM   = W'(Y_MAX);
    localparam logic [CW-1:0] DLY_END = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_END = CW'(REPEAT_PERIOD - 1);

    logic [3:0]    btn_m_q, btn_s_q;
    logic [3:0]    pat_q, pat_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  x_q, x_d, y_q, y_d;
    logic          moved_q, moved_d;
    logic          step;

    // btn_s bits: {up, down, left, right}
    logic b_up, b_down, b_left, b_right;
    assign b_up    = btn_s_q[3];
    assign b_down  = btn_s_q[2];
    assign b_left  = btn_s_q[1];
    assign b_right = btn_s_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        step    = 1'b0;
        // Release or a changed pattern drops back to IDLE before any tick is honoured
        if (btn_s_q == 4'd0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        step    = 1'b1;
                        state_d = S_DELAY;
                        cnt_d   = '0;
                        pat_d   = btn_s_q;
                    end
                end
                S_DELAY: begin
                    if (btn_s_q != pat_q) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == DLY_END) begin
                            step    = 1'b1;
                            state_d = S_REPEAT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                S_REPEAT: begin
                    if (btn_s_q != pat_q) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == PER_END) begin
                            step  = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        x_d = x_q;
        y_d = y_q;
        if (step) begin
            if (b_right && !b_left && x_q != X_LIM) x_d = x_q + W'(1);
            if (b_left && !b_right && x_q != '0)    x_d = x_q - W'(1);
            if (b_down && !b_up && y_q != Y_LIM)    y_d = y_q + W'(1);
            if (b_up && !b_down && y_q != '0)       y_d = y_q - W'(1);
        end
        moved_d = (x_d != x_q) || (y_d != y_q);

        if (clear) begin
            x_d     = X_CTR;
            y_d     = Y_CTR;
            state_d = S_IDLE;
            cnt_d   = '0;
            moved_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_m_q <= 4'd0;
            btn_s_q <= 4'd0;
            pat_q   <= 4'd0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
            moved_q <= 1'b0;
        end else begin
            btn_m_q <= btn;
            btn_s_q <= btn_m_q;
            pat_q   <= pat_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            moved_q <= moved_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign moved = moved_q;

endmodule

// File: tb/tb_cursor_stepper.sv
// tb/tb_cursor_stepper.sv - self-checking bench for cursor_stepper (default and fast-repeat instances)
module tb_cursor_stepper;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] btn = 4'd0;
    logic       clear = 1'b0;
    logic [9:0] x0, y0, x1, y1;
    logic       moved0, moved1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cursor_stepper dut (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn), .clear(clear),
        .x(x0), .y(y0), .moved(moved0)
    );

    cursor_stepper #(.REPEAT_DELAY(1), .REPEAT_PERIOD(1)) dut_fast (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn), .clear(clear),
        .x(x1), .y(y1), .moved(moved1)
    );

    // Reference model: counts ticks since the first step of a press and steps at
    // tick 0, then at DELAY, DELAY+PERIOD, ... Index 0 = default, 1 = fast.
    int   dly [2] = '{16, 1};
    int   per [2] = '{4, 1};
    int   mx  [2];
    int   my  [2];
    bit   mm  [2];
    bit   act [2];
    int   n   [2];
    logic [3:0] pat [2];
    logic [3:0] h1 = 4'd0, h2 = 4'd0, ms;
    int   nx, ny;
    bit   st;

    always @(posedge clk) begin
        ms = h2;
        if (!rst) begin
            h1 = 4'd0;
            h2 = 4'd0;
        end else begin
            h2 = h1;
            h1 = btn;
        end
        for (int i = 0; i < 2; i++) begin
            if (!rst || clear) begin
                mx[i] = 319; my[i] = 239; mm[i] = 1'b0; act[i] = 1'b0;
            end else begin
                st = 1'b0;
                if (ms == 4'd0) act[i] = 1'b0;
                else if (act[i] && ms != pat[i]) act[i] = 1'b0;
                else if (!act[i]) begin
                    if (tick) begin st = 1'b1; act[i] = 1'b1; pat[i] = ms; n[i] = 0; end
                end else if (tick) begin
                    n[i] = n[i] + 1;
                    st = (n[i] >= dly[i]) && (((n[i] - dly[i]) % per[i]) == 0);
                end
                nx = mx[i];
                ny = my[i];
                if (st) begin
                    nx = mx[i] + int'(ms[0]) - int'(ms[1]);
                    ny = my[i] + int'(ms[2]) - int'(ms[3]);
                    if (nx < 0) nx = 0;
                    if (nx > 639) nx = 639;
                    if (ny < 0) ny = 0;
                    if (ny > 479) ny = 479;
                end
                mm[i] = (nx != mx[i]) || (ny != my[i]);
                mx[i] = nx;
                my[i] = ny;
            end
        end
    end

    task automatic settle();
        btn = 4'd0; tick = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; btn = 4'hF; tick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (x0 !== 10'd319 || y0 !== 10'd239 || moved0 !== 1'b0 || x1 !== 10'd319 || y1 !== 10'd239 || moved1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_center: got (%0d,%0d,%0b)/(%0d,%0d,%0b) expected (319,239,0)", x0, y0, moved0, x1, y1, moved1);
        end
        rst = 1'b1; btn = 4'd0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
        end
        tests++;
        if (x0 !== 10'd319 || y0 !== 10'd239 || x1 !== 10'd319 || y1 !== 10'd239 || moved0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_btn_ignored: got (%0d,%0d)/(%0d,%0d) expected (319,239)", x0, y0, x1, y1);
        end
        tick = 1'b0;
    endtask

    task automatic test_single_press();
        int pulses = 0;
        settle();
        btn = 4'b0001;
        for (int k = 0; k < 60; k++) begin
            if (k == 40) btn = 4'd0;
            tick = (k % 4 == 3);
            @(posedge clk); #1;
            if (moved0) pulses++;
            tests++;
            if (x0 !== 10'(mx[0]) || y0 !== 10'(my[0]) || moved0 !== mm[0] || x1 !== 10'(mx[1]) || y1 !== 10'(my[1]) || moved1 !== mm[1]) begin
                fails++;
                $display("FAIL single_model k=%0d: got (%0d,%0d,%0b)/(%0d,%0d,%0b) expected (%0d,%0d,%0b)/(%0d,%0d,%0b)",
                         k, x0, y0, moved0, x1, y1, moved1, mx[0], my[0], mm[0], mx[1], my[1], mm[1]);
            end
        end
        tests++;
        if (x0 !== 10'd320 || pulses != 1) begin
            fails++;
            $display("FAIL single_press: got x=%0d pulses=%0d expected x=320 pulses=1", x0, pulses);
        end
    endtask

    task automatic test_auto_repeat();
        int pulses = 0;
        logic [9:0] seq [8];
        settle();
        btn = 4'b0001;
        for (int k = 0; k < 124; k++) begin
            tick = (k % 4 == 3);
            @(posedge clk); #1;
            if (moved0) begin
                if (pulses < 8) seq[pulses] = x0;
                pulses++;
            end
            tests++;
            if (x0 !== 10'(mx[0]) || y0 !== 10'(my[0]) || moved0 !== mm[0] || x1 !== 10'(mx[1]) || y1 !== 10'(my[1]) || moved1 !== mm[1]) begin
                fails++;
                $display("FAIL repeat_model k=%0d: got (%0d,%0d,%0b)/(%0d,%0d,%0b) expected (%0d,%0d,%0b)/(%0d,%0d,%0b)",
                         k, x0, y0, moved0, x1, y1, moved1, mx[0], my[0], mm[0], mx[1], my[1], mm[1]);
            end
        end
        tests++;
        if (pulses != 5) begin
            fails++;
            $display("FAIL repeat_pulses: got %0d expected 5", pulses);
        end
        for (int i = 0; i < 5 && i < pulses; i++) begin
            tests++;
            if (seq[i] !== 10'(320 + i)) begin
                fails++;
                $display("FAIL repeat_seq[%0d]: got %0d expected %0d", i, seq[i], 320 + i);
            end
        end
        btn = 4'd0;
    endtask

    task automatic test_saturation();
        int px = 0;
        int py = 0;
        settle();
        btn = 4'b0010; tick = 1'b1;
        for (int k = 0; k < 420; k++) begin
            @(posedge clk); #1;
            if (moved1) px++;
            tests++;
            if (x1 !== 10'(mx[1]) || moved1 !== mm[1] || x0 !== 10'(mx[0]) || moved0 !== mm[0]) begin
                fails++;
                $display("FAIL sat_x_model k=%0d: got x0=%0d/%0b x1=%0d/%0b expected %0d/%0b %0d/%0b",
                         k, x0, moved0, x1, moved1, mx[0], mm[0], mx[1], mm[1]);
            end
        end
        tests++;
        if (x1 !== 10'd0 || px != 319) begin
            fails++;
            $display("FAIL sat_x_left: got x=%0d pulses=%0d expected x=0 pulses=319", x1, px);
        end
        settle();
        btn = 4'b0100; tick = 1'b1;
        for (int k = 0; k < 420; k++) begin
            @(posedge clk); #1;
            if (moved1) py++;
            tests++;
            if (y1 !== 10'(my[1]) || moved1 !== mm[1] || y0 !== 10'(my[0]) || moved0 !== mm[0]) begin
                fails++;
                $display("FAIL sat_y_model k=%0d: got y0=%0d/%0b y1=%0d/%0b expected %0d/%0b %0d/%0b",
                         k, y0, moved0, y1, moved1, my[0], mm[0], my[1], mm[1]);
            end
        end
        tests++;
        if (y1 !== 10'd479 || py != 240) begin
            fails++;
            $display("FAIL sat_y_down: got y=%0d pulses=%0d expected y=479 pulses=240", y1, py);
        end
        btn = 4'd0; tick = 1'b0;
    endtask

    task automatic test_cancel_diag();
        int pulses = 0;
        settle();
        btn = 4'b0011; tick = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (moved0 || moved1) pulses++;
        end
        tests++;
        if (x0 !== 10'd319 || x1 !== 10'd319 || y0 !== 10'd239 || pulses != 0) begin
            fails++;
            $display("FAIL cancel_lr: got x0=%0d x1=%0d y0=%0d pulses=%0d expected 319,319,239,0", x0, x1, y0, pulses);
        end
        settle();
        btn = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            tick = (k % 4 == 3);
            @(posedge clk); #1;
        end
        tests++;
        if (x0 !== 10'd320 || y0 !== 10'd238) begin
            fails++;
            $display("FAIL diag_up_right: got (%0d,%0d) expected (320,238)", x0, y0);
        end
        btn = 4'd0; tick = 1'b0;
    endtask

    task automatic test_priority();
        settle();
        btn = 4'b0001;
        repeat (4) @(posedge clk);
        #1;
        tick = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0; clear = 1'b0;
        tests++;
        if (x0 !== 10'd319 || moved0 !== 1'b0 || x1 !== 10'd319 || moved1 !== 1'b0) begin
            fails++;
            $display("FAIL clear_beats_step: got x0=%0d/%0b x1=%0d/%0b expected 319/0", x0, moved0, x1, moved1);
        end
        @(posedge clk); #1;
        tests++;
        if (moved0 !== 1'b0 || x0 !== 10'd319) begin
            fails++;
            $display("FAIL clear_no_late_step: got x0=%0d moved=%0b expected 319/0", x0, moved0);
        end

        settle();
        btn = 4'b0001; tick = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k == 10) btn = 4'd0;
            @(posedge clk); #1;
            tests++;
            if (x1 !== 10'(mx[1]) || moved1 !== mm[1]) begin
                fails++;
                $display("FAIL release_model k=%0d: got x1=%0d/%0b expected %0d/%0b", k, x1, moved1, mx[1], mm[1]);
            end
        end
        tests++;
        if (x1 !== 10'd329) begin
            fails++;
            $display("FAIL release_on_tick: got x1=%0d expected 329", x1);
        end

        settle();
        btn = 4'b0001; tick = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; tick = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        tests++;
        if (x0 !== 10'd319 || y0 !== 10'd239 || moved0 !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_repeat: got (%0d,%0d,%0b) expected (319,239,0)", x0, y0, moved0);
        end
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        tests++;
        if (x0 !== 10'd320 || moved0 !== 1'b1) begin
            fails++;
            $display("FAIL press_after_rst: got x0=%0d moved=%0b expected 320/1", x0, moved0);
        end
        btn = 4'd0;
    endtask

    task automatic test_random();
        settle();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) btn = 4'($urandom_range(0, 15));
            tick  = ($urandom_range(0, 2) == 0);
            clear = ($urandom_range(0, 199) == 0);
            rst   = ($urandom_range(0, 499) != 0);
            @(posedge clk); #1;
            tests++;
            if (x0 !== 10'(mx[0]) || y0 !== 10'(my[0]) || moved0 !== mm[0] || x1 !== 10'(mx[1]) || y1 !== 10'(my[1]) || moved1 !== mm[1]) begin
                fails++;
                $display("FAIL random k=%0d: got (%0d,%0d,%0b)/(%0d,%0d,%0b) expected (%0d,%0d,%0b)/(%0d,%0d,%0b)",
                         k, x0, y0, moved0, x1, y1, moved1, mx[0], my[0], mm[0], mx[1], my[1], mm[1]);
            end
        end
        rst = 1'b1; clear = 1'b0; tick = 1'b0; btn = 4'd0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_auto_repeat();
        test_saturation();
        test_cancel_diag();
        test_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
